// File: rtl/axi_llc_way_arbiter.sv
// Burst-granular round-robin arbiter sharing the LLC data-way request port
// between cache units, with a registered output slice towards the data ways.
module axi_llc_way_arbiter #(
    parameter int unsigned NumUnits     = 4,
    parameter int unsigned PayloadWidth = 64,
    parameter int unsigned IdxWidth     = $clog2(NumUnits)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumUnits-1:0]              req_valid_i,
    output logic [NumUnits-1:0]              req_ready_o,
    input  logic [NumUnits-1:0]              req_last_i,
    input  logic [NumUnits*PayloadWidth-1:0] req_payload_i,
    output logic [PayloadWidth-1:0]          way_inp_o,
    output logic                             way_inp_valid_o,
    input  logic                             way_inp_ready_i,
    output logic [IdxWidth-1:0]              gnt_idx_o,
    output logic                             locked_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [IdxWidth-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IdxWidth-1:0]     lock_idx_q, lock_idx_d;
    logic                    out_valid_q;
    logic [PayloadWidth-1:0] out_payload_q;
    logic [IdxWidth-1:0]     gnt_q;

    logic                    take;
    logic                    found;
    logic                    hs;
    logic [IdxWidth-1:0]     cand;
    logic [IdxWidth-1:0]     winner;
    logic [IdxWidth-1:0]     sel_idx;
    logic [PayloadWidth-1:0] payload_arr [NumUnits];

    function automatic logic [IdxWidth-1:0] inc_wrap(input logic [IdxWidth-1:0] idx);
        return (idx == IdxWidth'(NumUnits - 1)) ? '0 : idx + 1'b1;
    endfunction

    for (genvar g = 0; g < NumUnits; g++) begin : g_unpack
        assign payload_arr[g] = req_payload_i[g*PayloadWidth +: PayloadWidth];
    end

    // First valid unit at or after the round-robin pointer, with wrap.
    always_comb begin
        winner = rr_ptr_q;
        found  = 1'b0;
        cand   = rr_ptr_q;
        for (int unsigned k = 0; k < NumUnits; k++) begin
            if (!found && req_valid_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
            cand = inc_wrap(cand);
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_idx_d  = lock_idx_q;
        req_ready_o = '0;
        sel_idx     = winner;
        take        = !out_valid_q || way_inp_ready_i;

        case (state_q)
            IDLE: begin
                sel_idx = winner;
                if (found && take && rst_ni) begin
                    req_ready_o[sel_idx] = 1'b1;
                end
            end
            LOCKED: begin
                sel_idx = lock_idx_q;
                if (take && rst_ni) begin
                    req_ready_o[sel_idx] = 1'b1;
                end
            end
            default: ;
        endcase

        hs = req_valid_i[sel_idx] && req_ready_o[sel_idx];

        // The pointer only moves at the end of a burst.
        if (hs) begin
            if (req_last_i[sel_idx]) begin
                state_d  = IDLE;
                rr_ptr_d = inc_wrap(sel_idx);
            end else begin
                state_d    = LOCKED;
                lock_idx_d = sel_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // Output slice: loads on handshake, empties when consumed with nothing new.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q   <= 1'b0;
            out_payload_q <= '0;
            gnt_q         <= '0;
        end else if (hs) begin
            out_valid_q   <= 1'b1;
            out_payload_q <= payload_arr[sel_idx];
            gnt_q         <= sel_idx;
        end else if (way_inp_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign way_inp_o       = out_payload_q;
    assign way_inp_valid_o = out_valid_q;
    assign gnt_idx_o       = gnt_q;
    assign locked_o        = (state_q == LOCKED);

endmodule

// File: tb/tb_axi_llc_way_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic compared
// against a transaction-level model of the burst round-robin arbiter.
module tb_axi_llc_way_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned PW = 64;
    localparam int unsigned IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_last = '0;
    logic [N*PW-1:0] req_payload = '0;
    logic [PW-1:0]   way_inp;
    logic            way_inp_valid;
    logic            way_ready = 1'b0;
    logic [IW-1:0]   gnt_idx;
    logic            locked;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit            m_valid;
    bit [PW-1:0]   m_payload;
    int            m_gnt;
    bit            m_locked;
    int            m_owner;
    int            m_ptr;
    bit            m_hs;
    int            m_sel;
    bit [PW-1:0]   held_payload;

    logic [N-1:0]  rv, rl;
    int            rem [N];

    axi_llc_way_arbiter #(
        .NumUnits    (N),
        .PayloadWidth(PW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_last_i     (req_last),
        .req_payload_i  (req_payload),
        .way_inp_o      (way_inp),
        .way_inp_valid_o(way_inp_valid),
        .way_inp_ready_i(way_ready),
        .gnt_idx_o      (gnt_idx),
        .locked_o       (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_valid   = 1'b0;
        m_payload = '0;
        m_gnt     = 0;
        m_locked  = 1'b0;
        m_owner   = 0;
        m_ptr     = 0;
        m_hs      = 1'b0;
        m_sel     = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(req_ready), 64'(0));
        check({tag, "_valid"}, 64'(way_inp_valid), 64'(0));
        check({tag, "_locked"}, 64'(locked), 64'(0));
        check({tag, "_gnt"}, 64'(gnt_idx), 64'(0));
        check({tag, "_payload"}, way_inp, 64'(0));
    endtask

    // One clock of stimulus: drive, check readies, clock, check registered outputs.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] l, input logic wr);
        logic [N-1:0] exp_ready;
        bit take, found, hs;
        int sel, c;
        req_valid = v;
        req_last  = l;
        way_ready = wr;
        for (int u = 0; u < N; u++) req_payload[u*PW +: PW] = {$urandom, $urandom};
        #1;
        take  = !m_valid || wr;
        found = 1'b0;
        sel   = 0;
        if (m_locked) begin
            sel   = m_owner;
            found = 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (!found && v[c]) begin
                    sel   = c;
                    found = 1'b1;
                end
            end
        end
        exp_ready = '0;
        if (take && found) exp_ready[sel] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        hs    = exp_ready[sel] && v[sel];
        m_hs  = hs;
        m_sel = sel;
        @(posedge clk);
        #1;
        if (hs) begin
            m_valid   = 1'b1;
            m_payload = req_payload[sel*PW +: PW];
            m_gnt     = sel;
            if (l[sel]) begin
                m_locked = 1'b0;
                m_ptr    = (sel + 1) % N;
            end else begin
                m_locked = 1'b1;
                m_owner  = sel;
            end
        end else if (wr) begin
            m_valid = 1'b0;
        end
        check("out_valid", 64'(way_inp_valid), 64'(m_valid));
        check("locked", 64'(locked), 64'(m_locked));
        if (m_valid) begin
            check("out_payload", way_inp, m_payload);
            check("out_gnt", 64'(gnt_idx), 64'(m_gnt));
        end
    endtask

    task automatic expect_beat(input string tag, input int g);
        check({tag, "_valid"}, 64'(way_inp_valid), 64'(1));
        check({tag, "_gnt"}, 64'(gnt_idx), 64'(g));
    endtask

    initial begin
        model_reset();
        req_valid = '1;
        #2;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin over single-beat requests
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 4'b1111, 1'b1);
            expect_beat("rr", k % N);
        end

        // Unit 3 four-beat burst while unit 1 waits
        step(4'b1000, 4'b0000, 1'b1);
        expect_beat("lock_b1", 3);
        check("lock_b1_locked", 64'(locked), 64'(1));
        for (int k = 0; k < 2; k++) begin
            step(4'b1010, 4'b0010, 1'b1);
            expect_beat("lock_mid", 3);
            check("lock_mid_locked", 64'(locked), 64'(1));
        end
        step(4'b1010, 4'b1010, 1'b1);
        expect_beat("lock_b4", 3);
        check("lock_b4_locked", 64'(locked), 64'(0));
        step(4'b0010, 4'b0010, 1'b1);
        expect_beat("lock_next", 1);

        // Backpressure with a held beat
        step(4'b1111, 4'b1111, 1'b1);
        expect_beat("bp_load", 2);
        held_payload = req_payload[2*PW +: PW];
        for (int k = 0; k < 3; k++) begin
            step(4'b1111, 4'b1111, 1'b0);
            check("bp_ready", 64'(req_ready), 64'(0));
            expect_beat("bp_hold", 2);
            check("bp_payload", way_inp, held_payload);
        end
        for (int k = 0; k < 4; k++) begin
            step(4'b1111, 4'b1111, 1'b1);
            expect_beat("bp_resume", (3 + k) % N);
        end

        // Wrap-around after a unit-2 burst leaves the pointer at 3
        step(4'b0100, 4'b0000, 1'b1);
        step(4'b0100, 4'b0100, 1'b1);
        expect_beat("wrap_b2", 2);
        step(4'b0011, 4'b0011, 1'b1);
        expect_beat("wrap_first", 0);
        step(4'b0011, 4'b0011, 1'b1);
        expect_beat("wrap_second", 1);

        // Unit 2 drops valid mid-burst; unit 0 must not be granted
        step(4'b0101, 4'b0001, 1'b1);
        expect_beat("gap_b1", 2);
        for (int k = 0; k < 2; k++) begin
            step(4'b0001, 4'b0001, 1'b1);
            check("gap_valid", 64'(way_inp_valid), 64'(0));
            check("gap_locked", 64'(locked), 64'(1));
        end
        step(4'b0101, 4'b0101, 1'b1);
        expect_beat("gap_b2", 2);
        step(4'b0101, 4'b0101, 1'b1);
        expect_beat("gap_after", 0);

        // Random bursty traffic with random backpressure
        for (int u = 0; u < N; u++) rem[u] = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int u = 0; u < N; u++) begin
                if (rem[u] == 0) rem[u] = $urandom_range(1, 4);
                rv[u] = ($urandom_range(0, 9) < 7);
                rl[u] = (rem[u] == 1);
            end
            step(rv, rl, ($urandom_range(0, 3) != 0));
            if (m_hs) rem[m_sel]--;
        end

        // Asynchronous reset in the middle of a burst
        step(4'b1111, 4'b0000, 1'b0);
        step(4'b1111, 4'b0000, 1'b1);
        req_valid = '1;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge clk);
        #1;
        check_reset_outputs("mid_rst_hold");
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        step(4'b1111, 4'b1111, 1'b1);
        expect_beat("post_rst", 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
